lsu_seq: RTL and testbench

- Multi-cycle sequencer and load/store front-end sitting directly upstream of the core's unified instruction/data memory.
- Generates the 3-bit `state` that the memory steps on: fetch in state 0, data access in state 3.
- Decodes load/store instructions into effective address, one-hot size strobes and store data; checks alignment before any access reaches memory.
- Returns the loaded value to register writeback.

---
 rtl/core_pkg.sv | 38 +++
 rtl/lsu_seq_if.sv | 22 ++
 rtl/lsu_decode.sv | 56 +++++
 rtl/lsu_seq.sv | 144 ++++++++++++++
 tb/tb_lsu_seq.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the load/store sequencer slice.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] TC_LOAD_MIS  = 2'd0;
  localparam logic [1:0] TC_STORE_MIS = 2'd1;
  localparam logic [1:0] TC_BAD_F3    = 2'd2;

  // One-hot size/sign strobes, order matches the memory-side port list.
  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
    logic sb;
    logic sh;
    logic sw;
  } strb_t;

endpackage

// File: rtl/lsu_seq_if.sv
// Memory-side bus between the sequencer and the unified memory.
interface lsu_seq_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] mem_rdata;
  logic        enabled;
  logic        load_enable;
  logic        store_enable;
  logic        is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw;

  modport master (
    output address, data_in, enabled, load_enable, store_enable,
           is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw,
    input  mem_rdata
  );

  modport slave (
    input  address, data_in, enabled, load_enable, store_enable,
           is_lb, is_lbu, is_lh, is_lhu, is_lw, is_sb, is_sh, is_sw,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_decode.sv
// Combinational load/store decode: strobes, effective address, fault flags.
module lsu_decode
  import core_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  output logic        is_load,
  output logic        is_store,
  output strb_t       strb,
  output logic [31:0] ea,
  output logic        bad_f3,
  output logic        misaligned
);
  logic [2:0]         funct3;
  logic signed [31:0] imm;
  logic               half;
  logic               word;
  logic               unused_rs1_field;

  assign funct3           = instr[14:12];
  assign is_load          = (instr[6:0] == OP_LOAD);
  assign is_store         = (instr[6:0] == OP_STORE);
  assign unused_rs1_field = ^instr[19:15];

  // Map funct3 to a size strobe; unsupported encodings raise bad_f3.
  always_comb begin
    strb   = '0;
    bad_f3 = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_B:    strb.lb  = 1'b1;
        F3_H:    strb.lh  = 1'b1;
        F3_W:    strb.lw  = 1'b1;
        F3_BU:   strb.lbu = 1'b1;
        F3_HU:   strb.lhu = 1'b1;
        default: bad_f3   = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_B:    strb.sb = 1'b1;
        F3_H:    strb.sh = 1'b1;
        F3_W:    strb.sw = 1'b1;
        default: bad_f3  = 1'b1;
      endcase
    end
  end

  // Stores split their immediate around the rd field; everything else uses I-type.
  assign imm = is_store ? {{20{instr[31]}}, instr[31:25], instr[11:7]}
                        : {{20{instr[31]}}, instr[31:20]};
  assign ea  = rs1_val + $unsigned(imm);

  assign half       = strb.lh | strb.lhu | strb.sh;
  assign word       = strb.lw | strb.sw;
  assign misaligned = (half & ea[0]) | (word & (ea[1:0] != 2'b00));
endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle sequencer and load/store front-end for the unified memory.
module lsu_seq
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            trap_ack,
  output logic [2:0]      state,
  output logic [XLEN-1:0] pc,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] load_result,
  output logic            trap,
  output logic [1:0]      trap_cause,
  output logic [XLEN-1:0] trap_addr,
  output logic [XLEN-1:0] instret,
  lsu_seq_if.master       mem
);
  state_t      state_q, state_d;
  logic        dec_load, dec_store, dec_bad_f3, dec_mis, fault;
  strb_t       dec_strb, strb_q;
  logic [31:0] dec_ea, address_q, data_in_q;
  logic        load_q, store_q, enabled_q;

  lsu_decode u_decode (
    .instr      (instr),
    .rs1_val    (rs1_val),
    .is_load    (dec_load),
    .is_store   (dec_store),
    .strb       (dec_strb),
    .ea         (dec_ea),
    .bad_f3     (dec_bad_f3),
    .misaligned (dec_mis)
  );

  assign fault = dec_bad_f3 | dec_mis;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next state: one step per unstalled cycle; TRAP ignores stall and waits for ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (!stall) state_d = ST_DECODE;
      ST_DECODE:  if (!stall) state_d = ST_EXECUTE;
      ST_EXECUTE: if (!stall) state_d = fault ? ST_TRAP : ST_MEM;
      ST_MEM:     if (!stall) state_d = ST_WB;
      ST_WB:      if (!stall) state_d = ST_FETCH;
      ST_TRAP:    if (trap_ack) state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Per-state register updates; rd_we is a single-cycle pulse after WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      instret     <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      strb_q      <= '0;
      enabled_q   <= 1'b0;
      address_q   <= '0;
      data_in_q   <= '0;
      load_result <= '0;
      rd_we       <= 1'b0;
      rd_addr     <= '0;
      trap_cause  <= '0;
      trap_addr   <= '0;
    end else begin
      rd_we <= 1'b0;
      case (state_q)
        ST_FETCH: ;
        ST_DECODE: if (!stall) begin
          load_q  <= dec_load;
          store_q <= dec_store;
          strb_q  <= dec_strb;
          rd_addr <= instr[11:7];
        end
        ST_EXECUTE: if (!stall) begin
          address_q <= dec_ea;
          data_in_q <= rs2_val;
          if (fault) begin
            trap_addr  <= dec_ea;
            trap_cause <= dec_bad_f3 ? TC_BAD_F3 : (store_q ? TC_STORE_MIS : TC_LOAD_MIS);
          end else begin
            enabled_q <= load_q | store_q;
          end
        end
        ST_MEM: if (!stall) enabled_q <= 1'b0;
        ST_WB: if (!stall) begin
          if (load_q) load_result <= mem.mem_rdata;
          rd_we   <= load_q && (rd_addr != 5'd0);
          pc      <= pc + 32'd4;
          instret <= instret + 32'd1;
          load_q  <= 1'b0;
          store_q <= 1'b0;
          strb_q  <= '0;
        end
        ST_TRAP: if (trap_ack) begin
          pc      <= pc + 32'd4;
          load_q  <= 1'b0;
          store_q <= 1'b0;
          strb_q  <= '0;
        end
        default: begin
          load_q    <= 1'b0;
          store_q   <= 1'b0;
          strb_q    <= '0;
          enabled_q <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;
  assign trap  = (state_q == ST_TRAP);

  // Reset gates the enable immediately so a store caught in MEM never lands.
  assign mem.enabled      = enabled_q & ~rst;
  assign mem.address      = address_q;
  assign mem.data_in      = data_in_q;
  assign mem.load_enable  = load_q;
  assign mem.store_enable = store_q;
  assign mem.is_lb        = strb_q.lb;
  assign mem.is_lbu       = strb_q.lbu;
  assign mem.is_lh        = strb_q.lh;
  assign mem.is_lhu       = strb_q.lhu;
  assign mem.is_lw        = strb_q.lw;
  assign mem.is_sb        = strb_q.sb;
  assign mem.is_sh        = strb_q.sh;
  assign mem.is_sw        = strb_q.sw;
endmodule

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq: instruction-level reference model, per-cycle compare, directed + random stimulus.
module tb_lsu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        trap_ack = 1'b0;
  logic [31:0] instr = '0, rs1_val = '0, rs2_val = '0;
  logic [2:0]  state;
  logic [31:0] pc, load_result, trap_addr, instret;
  logic        rd_we, trap;
  logic [4:0]  rd_addr;
  logic [1:0]  trap_cause;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  lsu_seq_if bus();

  lsu_seq #(.RESET_PC(32'h0), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .trap_ack(trap_ack), .state(state), .pc(pc), .rd_we(rd_we),
    .rd_addr(rd_addr), .load_result(load_result), .trap(trap), .trap_cause(trap_cause),
    .trap_addr(trap_addr), .instret(instret), .mem(bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPIMM = 7'b0010011;

  // ---- reference rules ----
  function automatic logic [7:0] m_strobe(logic [31:0] ins);
    if (ins[6:0] == LOAD)
      case (ins[14:12])
        3'd0: return 8'b1000_0000;
        3'd4: return 8'b0100_0000;
        3'd1: return 8'b0010_0000;
        3'd5: return 8'b0001_0000;
        3'd2: return 8'b0000_1000;
        default: return 8'h00;
      endcase
    if (ins[6:0] == STORE)
      case (ins[14:12])
        3'd0: return 8'b0000_0100;
        3'd1: return 8'b0000_0010;
        3'd2: return 8'b0000_0001;
        default: return 8'h00;
      endcase
    return 8'h00;
  endfunction

  function automatic int m_size(logic [31:0] ins);
    if (ins[6:0] == LOAD)
      case (ins[14:12])
        3'd0, 3'd4: return 1;
        3'd1, 3'd5: return 2;
        3'd2:       return 4;
        default:    return 0;
      endcase
    if (ins[6:0] == STORE)
      case (ins[14:12])
        3'd0:    return 1;
        3'd1:    return 2;
        3'd2:    return 4;
        default: return 0;
      endcase
    return 1;
  endfunction

  function automatic logic [31:0] m_ea(logic [31:0] ins, logic [31:0] rs1);
    logic [11:0] i12;
    if (ins[6:0] == STORE) i12 = {ins[31:25], ins[11:7]};
    else                   i12 = ins[31:20];
    return rs1 + {{20{i12[11]}}, i12};
  endfunction

  // -1 when the access is fine, otherwise the trap cause.
  function automatic int m_trap_code(logic [31:0] ins, logic [31:0] rs1);
    int sz;
    bit ld, st;
    ld = (ins[6:0] == LOAD);
    st = (ins[6:0] == STORE);
    sz = m_size(ins);
    if (!(ld || st)) return -1;
    if (sz == 0) return 2;
    if ((m_ea(ins, rs1) % sz) != 0) return ld ? 0 : 1;
    return -1;
  endfunction

  // ---- model state ----
  logic [2:0]  m_state;
  logic [31:0] m_pc, m_instret, m_addr, m_data, m_lres, m_taddr;
  logic [7:0]  m_strb;
  logic [4:0]  m_rd;
  logic [1:0]  m_cause;
  logic        m_ld, m_st, m_en, m_rdwe;

  always @(posedge clk) begin
    m_rdwe <= 1'b0;
    if (rst) begin
      m_state <= 3'd0; m_pc <= 32'h0; m_instret <= '0; m_addr <= '0; m_data <= '0;
      m_lres <= '0; m_taddr <= '0; m_strb <= '0; m_rd <= '0; m_cause <= '0;
      m_ld <= 1'b0; m_st <= 1'b0; m_en <= 1'b0;
    end else if (m_state == 3'd5) begin
      if (trap_ack) begin
        m_state <= 3'd0; m_pc <= m_pc + 32'd4;
        m_ld <= 1'b0; m_st <= 1'b0; m_strb <= '0;
      end
    end else if (!stall) begin
      case (m_state)
        3'd0: m_state <= 3'd1;
        3'd1: begin
          m_state <= 3'd2;
          m_ld    <= (instr[6:0] == LOAD);
          m_st    <= (instr[6:0] == STORE);
          m_strb  <= m_strobe(instr);
          m_rd    <= instr[11:7];
        end
        3'd2: begin
          m_addr <= m_ea(instr, rs1_val);
          m_data <= rs2_val;
          if (m_trap_code(instr, rs1_val) >= 0) begin
            m_state <= 3'd5;
            m_taddr <= m_ea(instr, rs1_val);
            m_cause <= 2'(m_trap_code(instr, rs1_val));
          end else begin
            m_state <= 3'd3;
            m_en    <= m_ld | m_st;
          end
        end
        3'd3: begin m_state <= 3'd4; m_en <= 1'b0; end
        default: begin
          if (m_ld) m_lres <= bus.mem_rdata;
          m_rdwe    <= m_ld && (m_rd != 5'd0);
          m_pc      <= m_pc + 32'd4;
          m_instret <= m_instret + 32'd1;
          m_ld <= 1'b0; m_st <= 1'b0; m_strb <= '0;
          m_state   <= 3'd0;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", {29'b0, state}, {29'b0, m_state});
      chk("pc", pc, m_pc);
      chk("instret", instret, m_instret);
      chk("address", bus.address, m_addr);
      chk("data_in", bus.data_in, m_data);
      chk("load_result", load_result, m_lres);
      chk("rd_we", {31'b0, rd_we}, {31'b0, m_rdwe});
      chk("rd_addr", {27'b0, rd_addr}, {27'b0, m_rd});
      chk("trap", {31'b0, trap}, {31'b0, (m_state == 3'd5)});
      chk("trap_cause", {30'b0, trap_cause}, {30'b0, m_cause});
      chk("trap_addr", trap_addr, m_taddr);
      chk("enabled", {31'b0, bus.enabled}, {31'b0, m_en & ~rst});
      chk("ld_st_en", {30'b0, bus.load_enable, bus.store_enable}, {30'b0, m_ld, m_st});
      chk("strobes", {24'b0, bus.is_lb, bus.is_lbu, bus.is_lh, bus.is_lhu,
                      bus.is_lw, bus.is_sb, bus.is_sh, bus.is_sw}, {24'b0, m_strb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [2:0]  lf3 [5];
    int          k;
    lf3[0] = 3'd0; lf3[1] = 3'd1; lf3[2] = 3'd2; lf3[3] = 3'd4; lf3[4] = 3'd5;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3)      return {r[31:15], lf3[$urandom_range(0, 4)], r[11:7], LOAD};
    else if (k <= 5) return {r[31:15], 3'(k - 4), r[11:7], STORE};
    else if (k == 6) return {r[31:12], r[11:7], STORE};
    else if (k == 7) return {r[31:12], r[11:7], OPIMM};
    else if (k == 8) return {r[31:12], r[11:7], LOAD};
    else             return r;
  endfunction

  initial begin
    bus.mem_rdata = '0;
    // Reset values.
    tick();
    cmp_en = 1'b1;
    tick();
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_enabled", {31'b0, bus.enabled}, 32'd0);

    // lw x5,4(x1), rs1=0x100.
    rst = 1'b0;
    instr = {12'd4, 5'd1, 3'd2, 5'd5, LOAD};
    rs1_val = 32'h100; rs2_val = 32'h0; bus.mem_rdata = 32'hDEAD_BEEF;
    tick(); chk("lw_dec", {29'b0, state}, 32'd1);
    tick(); tick();
    chk("lw_mem_state", {29'b0, state}, 32'd3);
    chk("lw_addr", bus.address, 32'h104);
    chk("lw_strobe", {31'b0, bus.is_lw}, 32'd1);
    chk("lw_en", {31'b0, bus.enabled}, 32'd1);
    tick(); chk("lw_wb", {29'b0, state}, 32'd4);
    tick();
    chk("lw_result", load_result, 32'hDEAD_BEEF);
    chk("lw_rdwe", {31'b0, rd_we}, 32'd1);
    chk("lw_rd", {27'b0, rd_addr}, 32'd5);
    chk("lw_pc", pc, 32'd4);
    chk("lw_instret", instret, 32'd1);

    // sb x2,-3(x1), rs1=0x203.
    instr = {7'h7F, 5'd2, 5'd1, 3'd0, 5'h1D, STORE};
    rs1_val = 32'h203; rs2_val = 32'h1234_56AB;
    tick(); tick(); tick();
    chk("sb_addr", bus.address, 32'h200);
    chk("sb_strobe", {31'b0, bus.is_sb}, 32'd1);
    chk("sb_data", bus.data_in, 32'h1234_56AB);
    chk("sb_trap", {31'b0, trap}, 32'd0);
    tick(); tick();
    chk("sb_rdwe", {31'b0, rd_we}, 32'd0);
    chk("sb_pc", pc, 32'd8);

    // lh x3,1(x1) at 0x101 -> misaligned load trap, held 3 cycles.
    instr = {12'd1, 5'd1, 3'd1, 5'd3, LOAD};
    rs1_val = 32'h100;
    tick(); tick(); tick();
    chk("lh_trap", {31'b0, trap}, 32'd1);
    chk("lh_cause", {30'b0, trap_cause}, 32'd0);
    chk("lh_taddr", trap_addr, 32'h101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lh_hold", {29'b0, state}, 32'd5);
      chk("lh_en", {31'b0, bus.enabled}, 32'd0);
    end
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;
    chk("lh_ack_state", {29'b0, state}, 32'd0);
    chk("lh_ack_pc", pc, 32'd12);
    chk("lh_instret", instret, 32'd2);

    // Load with funct3=3 -> bad funct3 trap.
    instr = {12'd0, 5'd1, 3'd3, 5'd4, LOAD};
    tick(); tick(); tick();
    chk("f3_cause", {30'b0, trap_cause}, 32'd2);
    trap_ack = 1'b1; tick(); trap_ack = 1'b0;

    // sw with rs1=0xFFFF_FFFC, imm=8 wraps to 0x4.
    instr = {7'd0, 5'd2, 5'd1, 3'd2, 5'd8, STORE};
    rs1_val = 32'hFFFF_FFFC;
    tick(); tick(); tick();
    chk("sw_addr", bus.address, 32'h4);
    chk("sw_trap", {31'b0, trap}, 32'd0);
    tick(); tick();
    chk("sw_pc", pc, 32'd20);
    chk("sw_instret", instret, 32'd3);

    // Stall 5 cycles in MEM, then reset while in MEM.
    instr = {12'd4, 5'd1, 3'd2, 5'd5, LOAD};
    rs1_val = 32'h100;
    tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_state", {29'b0, state}, 32'd3);
      chk("stall_addr", bus.address, 32'h104);
      chk("stall_en", {31'b0, bus.enabled}, 32'd1);
    end
    rst = 1'b1;
    #1 chk("rst_mem_en", {31'b0, bus.enabled}, 32'd0);
    tick();
    chk("rst_mem_state", {29'b0, state}, 32'd0);
    chk("rst_mem_instret", instret, 32'd0);
    rst = 1'b0; stall = 1'b0;

    // addi x7,x0,5: passes MEM without access.
    instr = {12'd5, 5'd0, 3'd0, 5'd7, OPIMM};
    tick(); tick(); tick();
    chk("addi_en", {31'b0, bus.enabled}, 32'd0);
    chk("addi_strobes", {24'b0, bus.is_lb, bus.is_lbu, bus.is_lh, bus.is_lhu,
                         bus.is_lw, bus.is_sb, bus.is_sh, bus.is_sw}, 32'd0);
    tick(); tick();
    chk("addi_instret", instret, 32'd1);

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 5) == 0);
      trap_ack = ($urandom_range(0, 2) == 0);
      rs1_val  = $urandom;
      rs2_val  = $urandom;
      bus.mem_rdata = $urandom;
      if (m_state == 3'd0) instr = gen_instr();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
